// File: rtl/hex_msg_scroller_if.sv
// Message-buffer write port for hex_msg_scroller.
// Switch/key logic is the master; the scroller is the slave.
interface hex_msg_scroller_if #(
  parameter int AW = 3
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_code;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_code
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_code
  );
endinterface

// File: rtl/hex_msg_scroller.sv
// Sliding-window message scroller driving DIGITS active-low
// seven-segment displays from a MSG_LEN-character buffer.
module hex_msg_scroller #(
  parameter int DIGITS  = 5,
  parameter int MSG_LEN = 8,
  parameter int DIV     = 50000000,
  localparam int AW     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
  localparam int DW     = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  hex_msg_scroller_if.slave     wr,
  input  logic                  run,
  input  logic                  dir,
  input  logic                  step,
  input  logic                  clear,
  output logic [7*DIGITS-1:0]   seg,
  output logic [AW-1:0]         ptr,
  output logic                  tick,
  output logic                  wrap
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_ARMED = 2'd2;

  localparam logic [AW-1:0] LAST = AW'(MSG_LEN - 1);
  localparam logic [DW-1:0] DTOP = DW'(DIV - 1);

  logic [2:0]    mem [MSG_LEN];
  logic [DW-1:0] div;
  logic [1:0]    state;
  logic          tick_c;
  logic          step_adv;
  logic          adv;
  logic [7*DIGITS-1:0] seg_d;
  logic [AW:0]   idx;

  function automatic logic [6:0] enc(input logic [2:0] code);
    logic [6:0] s;
    s = 7'h7F;
    unique case (code)
      3'd0: s = 7'h09;
      3'd1: s = 7'h4F;
      3'd2: s = 7'h03;
      3'd3: s = 7'h0C;
      3'd4: s = 7'h46;
      3'd5: s = 7'h06;
      3'd6: s = 7'h47;
      3'd7: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign tick_c   = run && !clear && (div == DTOP);
  // A step held across run falling still counts once, unless already taken.
  assign step_adv = !run && step && (state != S_ARMED);
  assign adv      = tick_c || step_adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else if (run) begin
      state <= S_RUN;
    end else if (step) begin
      state <= S_ARMED;
    end else begin
      state <= S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= tick_c;
      if (clear) begin
        div <= '0;
      end else if (run) begin
        div <= (div == DTOP) ? '0 : div + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else if (clear) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else if (adv) begin
      if (!dir) begin
        ptr  <= (ptr == LAST) ? '0 : ptr + 1'b1;
        wrap <= (ptr == LAST);
      end else begin
        ptr  <= (ptr == '0) ? LAST : ptr - 1'b1;
        wrap <= (ptr == '0);
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        mem[i] <= 3'd7;
      end
    end else if (wr.wr_en &&
                 ({1'b0, wr.wr_addr} < (AW+1)'(MSG_LEN))) begin
      mem[wr.wr_addr] <= wr.wr_code;
    end
  end

  always_comb begin
    seg_d = '1;
    idx   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      idx = {1'b0, ptr} + (AW+1)'(k);
      if (idx >= (AW+1)'(MSG_LEN)) begin
        idx = idx - (AW+1)'(MSG_LEN);
      end
      seg_d[7*k +: 7] = enc(mem[idx[AW-1:0]]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= '1;
    end else begin
      seg <= seg_d;
    end
  end

endmodule
